uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter for the TP2 serial path; the counterpart to the receiver side of the `uart` interface. Takes a parallel byte on a start strobe and serialises it onto `o_tx` as one start bit, SIZE_DATA data bits LSB first, and one stop bit. Bit timing comes from an external 16x-oversampling baud tick, the same tick the receiver uses. It sits between the result/response logic and the board TX pin.

## Interface

Parameters:
- SIZE_DATA, default 8: data bits per frame.
- SB_TICK, default 16: baud ticks in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_s_tick  in  1  baud tick, one-cycle pulse at 16x the baud rate.
- i_tx_start  in  1  start request, sampled only in IDLE.
- i_data  in  SIZE_DATA  byte to send, captured on an accepted start.
- o_tx  out  1  serial line, idle high, registered.
- o_busy  out  1  high while a frame is in progress (state != IDLE).
- o_tx_done_tick  out  1  one-cycle pulse when the frame completes.

## Operation

Internal registers:
- state (2 bits)
- tick counter s (4 bits minimum, wide enough for SB_TICK-1)
- bit counter n (clog2(SIZE_DATA) bits)
- shift register b (SIZE_DATA bits)
- tx_reg, which drives o_tx

States and transitions:
- IDLE:
  - tx_reg=1.
  - On i_tx_start=1: b<=i_data, s<=0, tx_reg<=0, go to START.
  - i_s_tick is ignored in IDLE.
- START:
  - tx_reg=0.
  - On each i_s_tick: if s==15, then s<=0, n<=0, tx_reg<=b[0], go to DATA; else s<=s+1.
- DATA:
  - tx_reg=b[0].
  - On i_s_tick with s==15: s<=0, b<=b>>1, and tx_reg takes the next bit.
  - If n==SIZE_DATA-1 at that point, tx_reg<=1 and go to STOP; else n<=n+1.
  - On i_s_tick with s!=15: s<=s+1.
- STOP:
  - tx_reg=1.
  - On i_s_tick with s==SB_TICK-1: go to IDLE and pulse o_tx_done_tick; else s<=s+1.

Rules:
- i_tx_start is ignored outside IDLE.
- i_data is don't-care after capture; changing it mid-frame must not affect the frame.
- Only ticks advance counters; clock cycles without i_s_tick hold all state.
- Reset (at any time, including mid-frame) sets state=IDLE, s=0, n=0, b=0, tx_reg=1, o_tx_done_tick=0. The line returns high on the next edge and the partial frame is abandoned with no done pulse.
- Reset has priority over i_tx_start in the same cycle.

## Timing

- Reset values: o_tx=1, o_busy=0, o_tx_done_tick=0.
- Start acceptance:
  - o_tx falls in the cycle after the edge that samples i_tx_start=1 in IDLE.
  - o_busy rises in that same cycle.
- Frame length: exactly 16*(1+SIZE_DATA)+SB_TICK ticks, counted from the first tick after acceptance.
- Bit widths on the line:
  - Start bit: 16 ticks.
  - Each data bit: 16 ticks.
  - Stop bit: SB_TICK ticks.
- Frame end, in the same cycle:
  - o_tx_done_tick is high for exactly one cycle, registered.
  - It is visible in the cycle after the edge consuming the final stop tick.
  - o_busy falls.
- Back-to-back frames:
  - i_tx_start asserted in the done cycle is accepted.
  - o_tx then stays high for exactly one extra clock after the stop bit before the next start bit.
- o_tx is glitch-free: it comes only from a flop and changes only on ticks or on start acceptance.

## Test plan

- Basic frame:
  - Stimulus: i_s_tick tied 1, i_data=0xA5, pulse start.
  - Response: o_tx low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles.
  - Done pulse once, 160 cycles after o_tx falls; o_busy high for exactly those 160 cycles.
- Sparse ticks:
  - Stimulus: tick every 4th cycle, i_data=0x00.
  - Response: o_tx low for 9*16*4=576 cycles, high for 64; done pulse once.
- Busy protection:
  - Stimulus: send 0x3C; mid-DATA assert i_tx_start with i_data=0xFF and change i_data.
  - Response: the serial bits still decode to 0x3C; only one done pulse.
- Back-to-back:
  - Stimulus: assert start with 0x55 in the done cycle of a 0xF0 frame.
  - Response: a single extra high cycle between frames; two done pulses; both bytes decode correctly.
- Reset mid-frame:
  - Stimulus: assert i_reset during data bit 3 of 0x81.
  - Response: next cycle o_tx=1, o_busy=0, no done pulse; a subsequent 0x81 frame is correct.
- Stop length:
  - Stimulus: SB_TICK=32, tick tied 1.
  - Response: stop bit is 32 cycles; total frame is 176 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-in / serial-out bundle for the UART transmitter.
// master drives tick/start/data; slave returns line, busy and done strobe.
interface uart_tx_if #(
  parameter int SIZE_DATA = 8
);
  logic                 i_s_tick;
  logic                 i_tx_start;
  logic [SIZE_DATA-1:0] i_data;
  logic                 o_tx;
  logic                 o_busy;
  logic                 o_tx_done_tick;

  modport master (
    output i_s_tick, i_tx_start, i_data,
    input  o_tx, o_busy, o_tx_done_tick
  );

  modport slave (
    input  i_s_tick, i_tx_start, i_data,
    output o_tx, o_busy, o_tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: start + SIZE_DATA bits LSB first + stop, on a 16x baud tick.
// Ports: i_clk, i_reset (sync, high), bus (uart_tx_if.slave).
module uart_tx #(
  parameter int SIZE_DATA = 8,
  parameter int SB_TICK   = 16
) (
  input logic      i_clk,
  input logic      i_reset,
  uart_tx_if.slave bus
);
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (SIZE_DATA > 1) ? $clog2(SIZE_DATA) : 1;
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(SIZE_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state_q, state_n;
  logic [SW-1:0]        s_q, s_n;
  logic [NW-1:0]        n_q, n_n;
  logic [SIZE_DATA-1:0] b_q, b_n, b_sh;
  logic                 tx_q, tx_n;
  logic                 done_q, done_n;

  assign b_sh = b_q >> 1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      n_q     <= n_n;
      b_q     <= b_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    n_n     = n_q;
    b_n     = b_q;
    tx_n    = tx_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_n = 1'b1;
        if (bus.i_tx_start) begin
          b_n     = bus.i_data;
          s_n     = '0;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bus.i_s_tick) begin
          if (s_q == S_BIT) begin
            s_n     = '0;
            n_n     = '0;
            tx_n    = b_q[0];
            state_n = DATA;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.i_s_tick) begin
          if (s_q == S_BIT) begin
            s_n = '0;
            b_n = b_sh;
            if (n_q == N_LAST) begin
              tx_n    = 1'b1;
              state_n = STOP;
            end else begin
              n_n  = n_q + 1'b1;
              tx_n = b_sh[0];
            end
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.i_s_tick) begin
          if (s_q == S_STOP) begin
            s_n     = '0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            s_n = s_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.o_tx           = tx_q;
  assign bus.o_busy         = (state_q != IDLE);
  assign bus.o_tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed frames decoded on the line, scoreboard of sent bytes.
// Two DUTs: stop bit of 16 ticks (a) and of 32 ticks (b).
module tb_uart_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [7:0] data_v = 8'h00;
  int         per = 1;
  int         tcnt = 0;
  int         npass = 0;
  int         nchk = 0;
  logic [7:0] exp_q[$];

  uart_tx_if ifa();
  uart_tx_if ifb();

  assign ifa.i_s_tick   = tick;
  assign ifb.i_s_tick   = tick;
  assign ifa.i_tx_start = start_a;
  assign ifb.i_tx_start = start_b;
  assign ifa.i_data     = data_v;
  assign ifb.i_data     = data_v;

  uart_tx #(.SIZE_DATA(8), .SB_TICK(16)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(ifa)
  );
  uart_tx #(.SIZE_DATA(8), .SB_TICK(32)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(ifb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tcnt >= per - 1) begin
      tcnt = 0;
      tick = 1'b1;
    end else begin
      tcnt = tcnt + 1;
      tick = 1'b0;
    end
  end

  function automatic logic tx_of(input bit b);
    return b ? ifb.o_tx : ifa.o_tx;
  endfunction
  function automatic logic busy_of(input bit b);
    return b ? ifb.o_busy : ifa.o_busy;
  endfunction
  function automatic logic done_of(input bit b);
    return b ? ifb.o_tx_done_tick : ifa.o_tx_done_tick;
  endfunction

  task automatic set_start(input bit b, input logic v);
    if (b) start_b = v;
    else start_a = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int tz(input logic [7:0] d);
    int c = 0;
    for (int k = 0; k < 8; k++) begin
      if (d[k]) return c;
      c++;
    end
    return c;
  endfunction

  // Sends d (unless already accepted: pre), decodes the frame, checks
  // timing; optionally chains the next byte nd in the done cycle, or
  // pokes start/data mid-DATA (mid).
  task automatic xfer(input bit b, input int sb, input logic [7:0] d,
                      input bit pre, input bit chain,
                      input logic [7:0] nd, input bit mid,
                      input string tag);
    logic [7:0] val;
    logic       stop_hi;
    int         low, len, bsy, lim, flen;
    bit         lead;
    val = '0; stop_hi = 1'b0; low = 0; len = -1; bsy = 0; lead = 1;
    flen = (16 * 9 + sb) * per;
    lim = flen + 8;
    if (!pre) begin
      @(negedge clk); #1;
      for (int w = 0; w < 16 && tick !== 1'b1; w++) begin
        @(negedge clk); #1;
      end
      data_v = d;
      set_start(b, 1'b1);
      exp_q.push_back(d);
      @(negedge clk);
      set_start(b, 1'b0);
    end
    chk({tag, " accept tx"}, 32'(tx_of(b)), 32'd0);
    chk({tag, " accept busy"}, 32'(busy_of(b)), 32'd1);
    for (int i = 0; i <= lim; i++) begin
      if (done_of(b) === 1'b1) begin
        len = i;
        break;
      end
      if (lead && tx_of(b) === 1'b0) low++;
      else lead = 0;
      if (busy_of(b) === 1'b1) bsy++;
      for (int k = 0; k < 8; k++)
        if (i == (16 * (k + 1) + 8) * per) val[k] = tx_of(b);
      if (i == (16 * 9 + sb / 2) * per) stop_hi = tx_of(b);
      if (mid && i == 48 * per) begin
        data_v = 8'hFF;
        set_start(b, 1'b1);
      end
      if (mid && i == 48 * per + 3) begin
        set_start(b, 1'b0);
        data_v = 8'h00;
      end
      @(negedge clk);
    end
    chk({tag, " frame len"}, 32'(len), 32'(flen));
    chk({tag, " busy cycles"}, 32'(bsy), 32'(flen));
    chk({tag, " low run"}, 32'(low), 32'(16 * per * (1 + tz(d))));
    chk({tag, " stop bit"}, 32'(stop_hi), 32'd1);
    if (exp_q.size() == 0) begin
      nchk++;
      $error("FAIL %s data: scoreboard empty, got %0h", tag, val);
    end else begin
      chk({tag, " data"}, 32'(val), 32'(exp_q.pop_front()));
    end
    if (len >= 0) begin
      chk({tag, " done tx"}, 32'(tx_of(b)), 32'd1);
      chk({tag, " done busy"}, 32'(busy_of(b)), 32'd0);
      if (chain) begin
        data_v = nd;
        set_start(b, 1'b1);
        exp_q.push_back(nd);
      end
      @(negedge clk);
      if (chain) set_start(b, 1'b0);
      chk({tag, " done width"}, 32'(done_of(b)), 32'd0);
      chk({tag, " after tx"}, 32'(tx_of(b)), chain ? 32'd0 : 32'd1);
    end
  endtask

  initial begin
    int dcnt;
    start_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(ifa.o_tx), 32'd1);
    chk("rst busy", 32'(ifa.o_busy), 32'd0);
    chk("rst done", 32'(ifa.o_tx_done_tick), 32'd0);
    chk("rst tx b", 32'(ifb.o_tx), 32'd1);
    rst = 1'b0;
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle busy", 32'(ifa.o_busy), 32'd0);

    per = 1;
    xfer(1'b0, 16, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, "basic");

    per = 4;
    xfer(1'b0, 16, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, "sparse");
    per = 1;
    repeat (3) @(negedge clk);

    xfer(1'b0, 16, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b1, "busyprot");
    repeat (4) @(negedge clk);
    chk("busyprot idle", 32'(ifa.o_busy), 32'd0);

    xfer(1'b0, 16, 8'hF0, 1'b0, 1'b1, 8'h55, 1'b0, "b2b_1");
    xfer(1'b0, 16, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0, "b2b_2");

    @(negedge clk); #1;
    data_v = 8'h81;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (72) @(negedge clk);
    chk("mid bit3 busy", 32'(ifa.o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst tx", 32'(ifa.o_tx), 32'd1);
    chk("mrst busy", 32'(ifa.o_busy), 32'd0);
    chk("mrst done", 32'(ifa.o_tx_done_tick), 32'd0);
    dcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (ifa.o_tx_done_tick === 1'b1) dcnt++;
    end
    chk("mrst no done", 32'(dcnt), 32'd0);
    chk("mrst line", 32'(ifa.o_tx), 32'd1);

    xfer(1'b0, 16, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0, "post_rst");

    xfer(1'b1, 32, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, "sb32");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
